// File: rtl/uart_tx_streamer.sv
// uart_tx_streamer: byte FIFO that drains into the UART TX data register.
//
// A producer pushes bytes with a valid/ready handshake. The streamer polls the
// UART status register and writes one byte to the TX data register each time
// the UART reports room. Steady-state throughput is one byte every two cycles.
//
// Ports:
//   clock, reset     single clock, synchronous active-high reset
//   in_valid/in_data producer byte offer; in_ready high while FIFO not full
//   uart_sel         one-cycle UART access strobe
//   uart_wr_enable   1 = write, 0 = read (valid with uart_sel)
//   uart_addr        UART register address
//   wdata_mem        write data {24'b0, byte}, zero outside a write
//   uart_data        UART read data (combinational for uart_addr)
//   busy             FIFO non-empty or FSM active
//   level            FIFO occupancy
//   stall            UART TX reported full for STALL_LIMIT consecutive polls
module uart_tx_streamer #(
  parameter int unsigned DEPTH        = 16,
  parameter logic [3:0]  TX_DATA_ADDR = 4'h0,
  parameter logic [3:0]  STATUS_ADDR  = 4'h8,
  parameter int unsigned TX_FULL_BIT  = 0,
  parameter int unsigned STALL_LIMIT  = 1024,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = $clog2(DEPTH) + 1,
  localparam int unsigned CntW = $clog2(STALL_LIMIT + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            uart_sel,
  output logic            uart_wr_enable,
  output logic [3:0]      uart_addr,
  output logic [31:0]     wdata_mem,
  input  logic [31:0]     uart_data,
  output logic            busy,
  output logic [LvlW-1:0] level,
  output logic            stall
);

  typedef enum logic [1:0] {StIdle, StPoll, StWrite} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic [CntW-1:0] full_cnt_q;
  logic            push, pop, tx_full;
  logic            unused_data;

  // Only the full flag of the status word matters here.
  assign unused_data = ^uart_data;

  assign in_ready = (level_q != LvlW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == StWrite);
  assign tx_full  = uart_data[TX_FULL_BIT];
  assign level    = level_q;
  assign busy     = (level_q != '0) || (state_q != StIdle);
  assign stall    = (full_cnt_q == CntW'(STALL_LIMIT));

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // IDLE looks at the post-edge level so a push made while idle starts a
  // poll on the very next cycle; WRITE uses it to include a concurrent push.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (level_d != '0) state_d = StPoll;
      StPoll:  if (!tx_full) state_d = StWrite;
      StWrite: state_d = (level_d != '0) ? StPoll : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Storage is not reset; emptiness is carried entirely by the pointers/level.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // State, pointers, stall counter and registered bus outputs. The bus
  // outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      level_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      full_cnt_q     <= '0;
      uart_sel       <= 1'b0;
      uart_wr_enable <= 1'b0;
      uart_addr      <= 4'h0;
      wdata_mem      <= 32'h0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);

      if (pop) begin
        full_cnt_q <= '0;
      end else if ((state_q == StPoll) && tx_full && !stall) begin
        full_cnt_q <= full_cnt_q + CntW'(1);
      end

      uart_sel       <= 1'b0;
      uart_wr_enable <= 1'b0;
      uart_addr      <= 4'h0;
      wdata_mem      <= 32'h0;
      unique case (state_d)
        StPoll: begin
          uart_sel  <= 1'b1;
          uart_addr <= STATUS_ADDR;
        end
        StWrite: begin
          // Head is stable across POLL since pops only happen in WRITE.
          uart_sel       <= 1'b1;
          uart_wr_enable <= 1'b1;
          uart_addr      <= TX_DATA_ADDR;
          wdata_mem      <= {24'h0, mem_q[rd_ptr_q]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_streamer.sv
module tb_uart_tx_streamer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned STALL = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        uart_sel;
  logic        uart_wr_enable;
  logic [3:0]  uart_addr;
  logic [31:0] wdata_mem;
  logic [31:0] uart_data;
  logic        busy;
  logic [4:0]  level;
  logic        stall;
  logic        uart_full;

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  int wr_cyc_q[$];

  assign uart_data = {31'h0, uart_full};

  always #5 clock = ~clock;

  uart_tx_streamer #(
    .DEPTH(DEPTH),
    .STALL_LIMIT(STALL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .uart_sel(uart_sel),
    .uart_wr_enable(uart_wr_enable),
    .uart_addr(uart_addr),
    .wdata_mem(wdata_mem),
    .uart_data(uart_data),
    .busy(busy),
    .level(level),
    .stall(stall)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; the UART bus is observed at the edge (pre-update values).
  task automatic tick();
    @(posedge clock);
    cyc++;
    if (uart_sel && uart_wr_enable) begin
      wr_cnt++;
      rx_q.push_back(wdata_mem[7:0]);
      wr_cyc_q.push_back(cyc);
    end else if (uart_sel) begin
      rd_cnt++;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int r0, w0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    uart_full = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_sel",    {31'h0, uart_sel}, 32'h0);
    check("rst_wr",     {31'h0, uart_wr_enable}, 32'h0);
    check("rst_addr",   {28'h0, uart_addr}, 32'h0);
    check("rst_wdata",  wdata_mem, 32'h0);
    check("rst_ready",  {31'h0, in_ready}, 32'h1);
    check("rst_busy",   {31'h0, busy}, 32'h0);
    check("rst_stall",  {31'h0, stall}, 32'h0);
    check("rst_level",  {27'h0, level}, 32'h0);

    // Single byte: POLL at N+1, WRITE at N+2, idle at N+3
    in_valid = 1'b1;
    in_data  = 8'h41;
    tick();
    in_valid = 1'b0;
    check("one_level1", {27'h0, level}, 32'h1);
    check("one_poll_sel", {31'h0, uart_sel}, 32'h1);
    check("one_poll_wr",  {31'h0, uart_wr_enable}, 32'h0);
    check("one_poll_addr", {28'h0, uart_addr}, 32'h8);
    check("one_poll_wdata", wdata_mem, 32'h0);
    tick();
    check("one_wr_sel",   {31'h0, uart_sel}, 32'h1);
    check("one_wr_wr",    {31'h0, uart_wr_enable}, 32'h1);
    check("one_wr_addr",  {28'h0, uart_addr}, 32'h0);
    check("one_wr_wdata", wdata_mem, 32'h41);
    tick();
    check("one_done_sel",   {31'h0, uart_sel}, 32'h0);
    check("one_done_busy",  {31'h0, busy}, 32'h0);
    check("one_done_level", {27'h0, level}, 32'h0);

    // Burst of 16 with UART held full so the FIFO fills, then drain
    rx_q.delete();
    wr_cyc_q.delete();
    uart_full = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      tick();
      check($sformatf("burst_level_%0d", k), {27'h0, level}, 32'(k + 1));
      check($sformatf("burst_ready_%0d", k), {31'h0, in_ready}, (k == 15) ? 32'h0 : 32'h1);
    end
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    check("burst_full_nopush", {27'h0, level}, 32'd16);
    uart_full = 1'b0;
    wait_idle("burst_idle");
    check("burst_count", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < rx_q.size(); i++) begin
      check($sformatf("burst_byte_%0d", i), {24'h0, rx_q[i]}, 32'(i));
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      check($sformatf("burst_gap_%0d", i), 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd2);
    end

    // Backpressure: 3 bytes, UART full for 50 cycles
    rx_q.delete();
    uart_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    repeat (50) tick();
    check("bp_reads",  32'(rd_cnt - r0), 32'd50);
    check("bp_writes", 32'(wr_cnt - w0), 32'd0);
    check("bp_level",  {27'h0, level}, 32'd3);
    uart_full = 1'b0;
    wait_idle("bp_idle");
    check("bp_count", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < rx_q.size(); i++) begin
      check($sformatf("bp_byte_%0d", i), {24'h0, rx_q[i]}, 32'hA0 + 32'(i));
    end

    // Stall after 8 full polls, cleared the cycle after the next WRITE
    rx_q.delete();
    check("stall_pre", {31'h0, stall}, 32'h0);
    uart_full = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("stall_after7", {31'h0, stall}, 32'h0);
    tick();
    check("stall_after8", {31'h0, stall}, 32'h1);
    uart_full = 1'b0;
    tick();
    check("stall_write_strobe", {31'h0, uart_sel && uart_wr_enable}, 32'h1);
    check("stall_in_write", {31'h0, stall}, 32'h1);
    tick();
    check("stall_cleared", {31'h0, stall}, 32'h0);
    wait_idle("stall_idle");
    check("stall_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("stall_byte", {24'h0, rx_q[0]}, 32'h55);

    // Continuous push while draining: level = c/2+1, WRITE on even c >= 2
    rx_q.delete();
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(c);
      check($sformatf("sim_level_%0d", c), {27'h0, level}, (c == 0) ? 32'h0 : 32'(c / 2 + 1));
      check($sformatf("sim_wr_%0d", c), {31'h0, uart_sel && uart_wr_enable},
            (c >= 2 && c % 2 == 0) ? 32'h1 : 32'h0);
      tick();
    end
    in_valid = 1'b0;
    wait_idle("sim_idle");
    check("sim_count", 32'(rx_q.size()), 32'd10);
    for (int i = 0; i < rx_q.size(); i++) begin
      check($sformatf("sim_byte_%0d", i), {24'h0, rx_q[i]}, 32'h60 + 32'(i));
    end

    // Reset in a WRITE cycle with 5 bytes queued
    uart_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(k);
      tick();
    end
    in_valid  = 1'b0;
    uart_full = 1'b0;
    tick();
    check("rstw_in_write", {31'h0, uart_sel && uart_wr_enable}, 32'h1);
    check("rstw_wdata", wdata_mem, 32'hC0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_sel",   {31'h0, uart_sel}, 32'h0);
    check("rstw_level", {27'h0, level}, 32'h0);
    check("rstw_ready", {31'h0, in_ready}, 32'h1);
    check("rstw_busy",  {31'h0, busy}, 32'h0);
    w0 = wr_cnt;
    repeat (20) tick();
    check("rstw_no_writes", 32'(wr_cnt - w0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
